// File: rtl/fastica_mul_seq.sv
// Streams a block of whitened sample vectors from the sample RAM through the 4x4
// matrix-vector multiplier, tagging each y with its sample index under y_ready backpressure.
//
// state  | meaning
// S_IDLE | no pass active, waiting for start
// S_RUN  | issuing sample reads, one address per non-stalled cycle
// S_DRAIN| all reads issued, waiting for the last y to be accepted
module fastica_mul_seq #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_mul,
  input  logic              rstn_mul,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_samples,
  output logic              busy,
  output logic              done,
  output logic              w_lock,
  output logic              z_rd_en,
  output logic [ADDR_W-1:0] z_rd_addr,
  output logic              en_mul,
  output logic              y_valid,
  output logic [ADDR_W-1:0] y_idx,
  input  logic              y_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_idx_q, s1_idx_d;
  logic              y_valid_q, y_valid_d;
  logic [ADDR_W-1:0] y_idx_q, y_idx_d;
  logic              done_q, done_d;

  logic              stall;
  logic              en_mul_c;
  logic              rd_en_c;
  logic [ADDR_W:0]   last_idx;
  logic              last_acc;

  assign stall    = y_valid_q & ~y_ready;
  assign last_idx = n_q - ONE;
  assign last_acc = y_valid_q & y_ready & (state_q == S_DRAIN) &
                    ({1'b0, y_idx_q} == last_idx);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    rd_cnt_d   = rd_cnt_q;
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    done_d     = 1'b0;
    rd_en_c    = 1'b0;
    en_mul_c   = s1_valid_q & ~stall;
    y_valid_d  = en_mul_c | stall;
    y_idx_d    = en_mul_c ? s1_idx_q : y_idx_q;

    case (state_q)
      S_IDLE: begin
        if (!stall) s1_valid_d = 1'b0;
        if (start) begin
          if (num_samples != '0) begin
            n_d        = num_samples;
            rd_cnt_d   = '0;
            s1_valid_d = 1'b0;
            state_d    = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          rd_en_c    = 1'b1;
          rd_cnt_d   = rd_cnt_q + ONE;
          s1_valid_d = 1'b1;
          s1_idx_d   = rd_cnt_q[ADDR_W-1:0];
          if (rd_cnt_q == last_idx) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!stall) s1_valid_d = 1'b0;
        if (last_acc) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // abort wins over everything, including a start in the same cycle
    if (abort) begin
      state_d    = S_IDLE;
      s1_valid_d = 1'b0;
      y_valid_d  = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_mul or negedge rstn_mul) begin
    if (!rstn_mul) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      rd_cnt_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      y_valid_q  <= 1'b0;
      y_idx_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rd_cnt_q   <= rd_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      y_valid_q  <= y_valid_d;
      y_idx_q    <= y_idx_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign w_lock    = busy;
  assign done      = done_q;
  assign z_rd_en   = rd_en_c;
  assign z_rd_addr = rd_cnt_q[ADDR_W-1:0];
  assign en_mul    = en_mul_c;
  assign y_valid   = y_valid_q;
  assign y_idx     = y_idx_q;

endmodule

// File: tb/tb_fastica_mul_seq.sv
// Directed bench for fastica_mul_seq: a behavioural sample RAM and multiplier
// carry a per-index tag so each y can be matched to the index it should belong to.
module tb_fastica_mul_seq;

  logic        clk_mul = 1'b0;
  logic        rstn_mul, start, abort, y_ready;
  logic [10:0] num_samples;
  logic        busy, done, w_lock, z_rd_en, en_mul, y_valid;
  logic [9:0]  z_rd_addr, y_idx;

  logic        rstn3, start3, abort3, y_ready3;
  logic [3:0]  num3;
  logic        busy3, done3, w_lock3, z_rd_en3, en_mul3, y_valid3;
  logic [2:0]  z_rd_addr3, y_idx3;

  logic [15:0] ram_q, y_data;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk_mul = ~clk_mul;

  fastica_mul_seq #(.ADDR_W(10)) dut (
    .clk_mul(clk_mul), .rstn_mul(rstn_mul), .start(start), .abort(abort),
    .num_samples(num_samples), .busy(busy), .done(done), .w_lock(w_lock),
    .z_rd_en(z_rd_en), .z_rd_addr(z_rd_addr), .en_mul(en_mul),
    .y_valid(y_valid), .y_idx(y_idx), .y_ready(y_ready)
  );

  fastica_mul_seq #(.ADDR_W(3)) dut3 (
    .clk_mul(clk_mul), .rstn_mul(rstn3), .start(start3), .abort(abort3),
    .num_samples(num3), .busy(busy3), .done(done3), .w_lock(w_lock3),
    .z_rd_en(z_rd_en3), .z_rd_addr(z_rd_addr3), .en_mul(en_mul3),
    .y_valid(y_valid3), .y_idx(y_idx3), .y_ready(y_ready3)
  );

  function automatic logic [15:0] zf(input int a);
    return 16'(a * 5 + 3);
  endfunction

  // RAM holds its output when not read; multiplier output holds when not enabled
  always_ff @(posedge clk_mul) begin
    if (z_rd_en) ram_q <= zf(int'(z_rd_addr));
    if (en_mul) y_data <= ram_q;
  end

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return (c % 3) == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk_mul);
    #1;
  endtask

  task automatic run_pass(input int n, input int mode, input int xs_cyc, input logic [10:0] xs_num);
    int acc = 0;
    int dn = 0;
    int exp_idx = 0;
    logic prev_stall = 1'b0;
    start = 1'b1; num_samples = 11'(n); y_ready = rdy(mode, 0);
    next_cyc();
    start = 1'b0;
    for (int c = 1; c < 300 && dn == 0; c++) begin
      y_ready = rdy(mode, c);
      start = (c == xs_cyc);
      if (c == xs_cyc) num_samples = xs_num;
      @(negedge clk_mul);
      if (prev_stall) chk("valid_held", 32'(y_valid), 32'd1);
      if (y_valid && !y_ready) begin
        chk("stall_rd_en", 32'(z_rd_en), 32'd0);
        chk("stall_en_mul", 32'(en_mul), 32'd0);
      end
      if (y_valid) begin
        chk("y_idx_order", 32'(y_idx), 32'(exp_idx));
        chk("y_data", 32'(y_data), 32'(zf(exp_idx)));
      end
      chk("busy_run", 32'(busy), done ? 32'd0 : 32'd1);
      prev_stall = y_valid & ~y_ready;
      if (y_valid && y_ready) begin
        acc++;
        exp_idx++;
      end
      if (done) dn++;
      next_cyc();
    end
    start = 1'b0;
    chk("accepted", 32'(acc), 32'(n));
    chk("done_cnt", 32'(dn), 32'd1);
    @(negedge clk_mul);
    chk("done_after", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    next_cyc();
  endtask

  initial begin
    rstn_mul = 1'b0; start = 1'b0; abort = 1'b0; y_ready = 1'b1; num_samples = '0;
    rstn3 = 1'b0; start3 = 1'b0; abort3 = 1'b0; y_ready3 = 1'b1; num3 = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wlock", 32'(w_lock), 32'd0);
    chk("rst_rd_en", 32'(z_rd_en), 32'd0);
    chk("rst_en_mul", 32'(en_mul), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_addr", 32'(z_rd_addr), 32'd0);
    chk("rst_y_idx", 32'(y_idx), 32'd0);
    next_cyc();
    rstn_mul = 1'b1; rstn3 = 1'b1;
    next_cyc();

    // N=4, y_ready high: exact cycle-by-cycle latency
    start = 1'b1; num_samples = 11'd4;
    next_cyc();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_mul);
      chk("n4_rd_en", 32'(z_rd_en), (c <= 4) ? 32'd1 : 32'd0);
      if (c <= 4) chk("n4_addr", 32'(z_rd_addr), 32'(c - 1));
      chk("n4_en_mul", 32'(en_mul), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
      chk("n4_y_valid", 32'(y_valid), (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
      if (c >= 3 && c <= 6) begin
        chk("n4_y_idx", 32'(y_idx), 32'(c - 3));
        chk("n4_y_data", 32'(y_data), 32'(zf(c - 3)));
      end
      chk("n4_done", 32'(done), (c == 7) ? 32'd1 : 32'd0);
      chk("n4_busy", 32'(busy), (c <= 6) ? 32'd1 : 32'd0);
      chk("n4_wlock", 32'(w_lock), (c <= 6) ? 32'd1 : 32'd0);
      next_cyc();
    end

    // N=8 under 1,0,0 backpressure
    run_pass(8, 1, 0, '0);

    // num_samples=0: done only
    start = 1'b1; num_samples = '0;
    next_cyc();
    start = 1'b0;
    @(negedge clk_mul);
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_rd_en", 32'(z_rd_en), 32'd0);
    chk("z_en_mul", 32'(en_mul), 32'd0);
    next_cyc();
    @(negedge clk_mul);
    chk("z_done_once", 32'(done), 32'd0);
    chk("z_busy2", 32'(busy), 32'd0);
    next_cyc();

    // abort at cycle 3 of an N=16 pass
    start = 1'b1; num_samples = 11'd16;
    next_cyc();
    start = 1'b0;
    next_cyc();
    next_cyc();
    abort = 1'b1;
    @(negedge clk_mul);
    chk("ab_pre_valid", 32'(y_valid), 32'd1);
    next_cyc();
    abort = 1'b0;
    @(negedge clk_mul);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_wlock", 32'(w_lock), 32'd0);
    chk("ab_y_valid", 32'(y_valid), 32'd0);
    chk("ab_rd_en", 32'(z_rd_en), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    next_cyc();
    @(negedge clk_mul);
    chk("ab_done2", 32'(done), 32'd0);
    chk("ab_en_mul", 32'(en_mul), 32'd0);
    next_cyc();
    run_pass(2, 0, 0, '0);

    // second start during an N=6 pass is ignored
    run_pass(6, 0, 2, 11'd3);

    // ADDR_W=3, N=8: full address space
    start3 = 1'b1; num3 = 4'd8;
    next_cyc();
    start3 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk_mul);
      chk("a3_rd_en", 32'(z_rd_en3), (c <= 8) ? 32'd1 : 32'd0);
      if (c <= 8) chk("a3_addr", 32'(z_rd_addr3), 32'(c - 1));
      chk("a3_y_valid", 32'(y_valid3), (c >= 3 && c <= 10) ? 32'd1 : 32'd0);
      if (c >= 3 && c <= 10) chk("a3_y_idx", 32'(y_idx3), 32'(c - 3));
      chk("a3_busy", 32'(busy3), (c <= 10) ? 32'd1 : 32'd0);
      chk("a3_done", 32'(done3), (c == 11) ? 32'd1 : 32'd0);
      next_cyc();
    end

    // asynchronous reset mid-pass
    start3 = 1'b1; num3 = 4'd8;
    next_cyc();
    start3 = 1'b0;
    for (int c = 1; c < 4; c++) next_cyc();
    @(negedge clk_mul);
    chk("ar_pre_busy", 32'(busy3), 32'd1);
    #2 rstn3 = 1'b0;
    #1;
    chk("ar_busy", 32'(busy3), 32'd0);
    chk("ar_wlock", 32'(w_lock3), 32'd0);
    chk("ar_y_valid", 32'(y_valid3), 32'd0);
    chk("ar_en_mul", 32'(en_mul3), 32'd0);
    chk("ar_rd_en", 32'(z_rd_en3), 32'd0);
    chk("ar_addr", 32'(z_rd_addr3), 32'd0);
    chk("ar_y_idx", 32'(y_idx3), 32'd0);
    chk("ar_done", 32'(done3), 32'd0);
    next_cyc();
    rstn3 = 1'b1;
    next_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
